// File: rtl/matmul_seq_if.sv
// ----------------------------------------------------------------------------
// matmul_seq_if
// Purpose : groups the operand/dimension inputs and the feed/status outputs of
//           the matmul_seq sequencer into one bundle. Clock and reset are kept
//           as plain ports on the sequencer itself.
// Modports:
//   master : scratchpad-control side (drives start/operands/dims, observes feeds)
//   slave  : sequencer side (matmul_seq)
// Signals :
//   start_i      level request, held high for the whole operation
//   a_in_i       matrix A, word r = row r, element k = A[r][k]
//   b_in_i       matrix B, word k = row k, element c = B[k][c]
//   dim_*_i      dimension codes, size = code + 1
//   a_feed_o     skewed A element per PE-array row
//   b_feed_o     skewed B element per PE-array column
//   feed_valid_o feed vectors valid this cycle
//   clr_acc_o    one-cycle accumulator clear
//   done_o       one-cycle completion pulse (scratchpad write strobe)
//   busy_o       high from LOAD through DONE
// ----------------------------------------------------------------------------
interface matmul_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32
);
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;

    logic                            start_i;
    logic [MAX_DIM*BUS_WIDTH-1:0]    a_in_i;
    logic [MAX_DIM*BUS_WIDTH-1:0]    b_in_i;
    logic [1:0]                      dim_n_i;
    logic [1:0]                      dim_k_i;
    logic [1:0]                      dim_m_i;
    logic [MAX_DIM*DATA_WIDTH-1:0]   a_feed_o;
    logic [MAX_DIM*DATA_WIDTH-1:0]   b_feed_o;
    logic                            feed_valid_o;
    logic                            clr_acc_o;
    logic                            done_o;
    logic                            busy_o;

    modport master (
        output start_i, a_in_i, b_in_i, dim_n_i, dim_k_i, dim_m_i,
        input  a_feed_o, b_feed_o, feed_valid_o, clr_acc_o, done_o, busy_o
    );

    modport slave (
        input  start_i, a_in_i, b_in_i, dim_n_i, dim_k_i, dim_m_i,
        output a_feed_o, b_feed_o, feed_valid_o, clr_acc_o, done_o, busy_o
    );
endinterface

// File: rtl/matmul_seq.sv
// ----------------------------------------------------------------------------
// matmul_seq
// Purpose : sequencer that feeds a systolic PE array. It latches an A (NxK)
//           and a B (KxM) operand block, clears the accumulators, then streams
//           the operands diagonally skewed (lane r of A delayed by r cycles,
//           lane c of B delayed by c cycles) for N+M+K-2 cycles, waits
//           PIPE_LAT drain cycles and pulses done_o.
// Ports   :
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   bus          matmul_seq_if.slave (start, operands, dims, feeds, status)
//   cycle_cnt_o  (only with MATMUL_SEQ_PERF_EN) LOAD..DONE cycle count,
//                saturating, held until the next LOAD
// Options : define MATMUL_SEQ_PERF_EN to add the cycle counter.
// Notes   : every output is driven straight from a register. Dropping start_i
//           before DONE aborts the operation without a done_o pulse.
// ----------------------------------------------------------------------------
module matmul_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int PIPE_LAT   = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    matmul_seq_if.slave bus
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [15:0] cycle_cnt_o
`endif
);
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
    localparam int OP_W       = MAX_DIM * BUS_WIDTH;
    localparam int FEED_W     = MAX_DIM * DATA_WIDTH;
    // Wide enough to hold N+M+K (at most 3*MAX_DIM); never narrower than
    // the 2-bit dimension code plus one.
    localparam int STEP_W_RAW = $clog2(3 * MAX_DIM + 1);
    localparam int STEP_W     = (STEP_W_RAW < 3) ? 3 : STEP_W_RAW;
    localparam logic [STEP_W-1:0] MAX_CODE = STEP_W'(MAX_DIM - 1);
    localparam logic [2:0]        DRAIN_END = 3'(PIPE_LAT);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_FEED    = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5,
        ST_RELEASE = 3'd6
    } state_e;

    state_e               state_q;
    logic [OP_W-1:0]      a_q;
    logic [OP_W-1:0]      b_q;
    logic [STEP_W-1:0]    n_q;
    logic [STEP_W-1:0]    k_q;
    logic [STEP_W-1:0]    m_q;
    logic [STEP_W-1:0]    last_q;      // final feed step index N+M+K-3
    logic [STEP_W-1:0]    step_q;      // step currently on the feed outputs
    logic [2:0]           drain_q;
    logic [FEED_W-1:0]    a_feed_q;
    logic [FEED_W-1:0]    b_feed_q;
    logic                 feed_valid_q;
    logic                 clr_acc_q;
    logic                 done_q;
    logic                 busy_q;

    logic [STEP_W-1:0]    n_in_s;
    logic [STEP_W-1:0]    k_in_s;
    logic [STEP_W-1:0]    m_in_s;
    logic [STEP_W-1:0]    last_in_s;
    logic [STEP_W-1:0]    step_sel_s;
    logic [FEED_W-1:0]    a_feed_d;
    logic [FEED_W-1:0]    b_feed_d;

    // Dimension code -> size, with codes beyond the array clamped to its edge.
    function automatic logic [STEP_W-1:0] clamp_size(input logic [1:0] code);
        logic [STEP_W-1:0] ext;
        ext = STEP_W'(code);
        if (ext > MAX_CODE) begin
            ext = MAX_CODE;
        end else begin
            ext = ext;
        end
        return ext + STEP_W'(1'b1);
    endfunction

    assign n_in_s    = clamp_size(bus.dim_n_i);
    assign k_in_s    = clamp_size(bus.dim_k_i);
    assign m_in_s    = clamp_size(bus.dim_m_i);
    assign last_in_s = n_in_s + k_in_s + m_in_s - STEP_W'(2'd3);

    // Skewed feed vectors for the step that will be presented next cycle.
    // A[r][k] belongs on lane r at step r+k; B[k][c] on lane c at step k+c.
    always_comb begin
        step_sel_s = '0;
        a_feed_d   = '0;
        b_feed_d   = '0;
        if (state_q == ST_FEED) begin
            step_sel_s = step_q + STEP_W'(1'b1);
        end else begin
            step_sel_s = '0;
        end
        for (int r = 0; r < MAX_DIM; r++) begin
            for (int k = 0; k < MAX_DIM; k++) begin
                a_feed_d[r*DATA_WIDTH +: DATA_WIDTH] = a_feed_d[r*DATA_WIDTH +: DATA_WIDTH] |
                    (((STEP_W'(r) < n_q) && (STEP_W'(k) < k_q) && (step_sel_s == STEP_W'(r + k)))
                        ? a_q[r*BUS_WIDTH + k*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}});
                b_feed_d[r*DATA_WIDTH +: DATA_WIDTH] = b_feed_d[r*DATA_WIDTH +: DATA_WIDTH] |
                    (((STEP_W'(r) < m_q) && (STEP_W'(k) < k_q) && (step_sel_s == STEP_W'(r + k)))
                        ? b_q[k*BUS_WIDTH + r*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}});
            end
        end
    end

    // Sequencer FSM: state, latched operands and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            n_q          <= '0;
            k_q          <= '0;
            m_q          <= '0;
            last_q       <= '0;
            step_q       <= '0;
            drain_q      <= 3'd0;
            a_feed_q     <= '0;
            b_feed_q     <= '0;
            feed_valid_q <= 1'b0;
            clr_acc_q    <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // Pulse and feed outputs are zero unless a state below sets them.
            a_feed_q     <= '0;
            b_feed_q     <= '0;
            feed_valid_q <= 1'b0;
            clr_acc_q    <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (!bus.start_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        a_q       <= bus.a_in_i;
                        b_q       <= bus.b_in_i;
                        n_q       <= n_in_s;
                        k_q       <= k_in_s;
                        m_q       <= m_in_s;
                        last_q    <= last_in_s;
                        state_q   <= ST_CLEAR;
                        clr_acc_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (!bus.start_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q      <= ST_FEED;
                        step_q       <= '0;
                        feed_valid_q <= 1'b1;
                        a_feed_q     <= a_feed_d;
                        b_feed_q     <= b_feed_d;
                    end
                end
                ST_FEED: begin
                    if (!bus.start_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        step_q  <= '0;
                    end else if (step_q == last_q) begin
                        state_q <= ST_DRAIN;
                        step_q  <= '0;
                        drain_q <= 3'd1;
                    end else begin
                        step_q       <= step_q + STEP_W'(1'b1);
                        feed_valid_q <= 1'b1;
                        a_feed_q     <= a_feed_d;
                        b_feed_q     <= b_feed_d;
                    end
                end
                ST_DRAIN: begin
                    if (!bus.start_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        drain_q <= 3'd0;
                    end else if (drain_q == DRAIN_END) begin
                        state_q <= ST_DONE;
                        drain_q <= 3'd0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    // done_o is already on the wire; start_i only picks the exit.
                    busy_q <= 1'b0;
                    if (bus.start_i) begin
                        state_q <= ST_RELEASE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RELEASE: begin
                    // Wait for start_i to drop so a held request cannot re-run.
                    busy_q <= 1'b0;
                    if (!bus.start_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RELEASE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_feed_o     = a_feed_q;
    assign bus.b_feed_o     = b_feed_q;
    assign bus.feed_valid_o = feed_valid_q;
    assign bus.clr_acc_o    = clr_acc_q;
    assign bus.done_o       = done_q;
    assign bus.busy_o       = busy_q;

`ifdef MATMUL_SEQ_PERF_EN
    logic [15:0] cycle_cnt_q;

    // Operation length counter: restarts on LOAD entry, counts LOAD..DONE
    // (busy_q mirrors exactly those states), saturates, holds otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_q <= 16'd0;
        end else if ((state_q == ST_IDLE) && bus.start_i) begin
            cycle_cnt_q <= 16'd0;
        end else if (busy_q && (cycle_cnt_q != 16'hFFFF)) begin
            cycle_cnt_q <= cycle_cnt_q + 16'd1;
        end else begin
            cycle_cnt_q <= cycle_cnt_q;
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_matmul_seq.sv
// ----------------------------------------------------------------------------
// tb_matmul_seq
// Scoreboarded bench for matmul_seq. Each operation pushes the clear pulse,
// every skewed feed vector and the done pulse (with the cycle each must appear
// in) into a queue; a negedge monitor pops and compares every output event.
// Cycle c is the period after the c-th rising edge; an operation whose start_i
// is first sampled at the end of cycle s shows LOAD in s+1, clear in s+2,
// feed step t in s+3+t and done in s+3+F+PIPE_LAT.
// ----------------------------------------------------------------------------
module tb_matmul_seq;
    localparam int DW  = 8;
    localparam int BW  = 32;
    localparam int PL  = 1;
    localparam int MD  = BW / DW;
    localparam int OPW = MD * BW;
    localparam int FW  = MD * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matmul_seq_if #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) bus ();

`ifdef MATMUL_SEQ_PERF_EN
    logic [15:0] cycle_cnt;
`endif

    matmul_seq #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .PIPE_LAT(PL)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef MATMUL_SEQ_PERF_EN
        ,
        .cycle_cnt_o (cycle_cnt)
`endif
    );

    typedef struct {
        int            kind;   // 0 clear, 1 feed, 2 done
        int            cyc;
        logic [FW-1:0] a;
        logic [FW-1:0] b;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] ma [MD][MD];
    logic [DW-1:0] mb [MD][MD];
    int            cyc      = 0;
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference: lane r of A carries A[r][t-r], lane c of B carries B[t-c][c].
    function automatic logic [FW-1:0] model_a(input int t, input int n, input int k);
        logic [FW-1:0] v = '0;
        for (int r = 0; r < MD; r++)
            if (r < n && t - r >= 0 && t - r < k) v[r*DW +: DW] = ma[r][t-r];
        return v;
    endfunction

    function automatic logic [FW-1:0] model_b(input int t, input int k, input int m);
        logic [FW-1:0] v = '0;
        for (int c = 0; c < MD; c++)
            if (c < m && t - c >= 0 && t - c < k) v[c*DW +: DW] = mb[t-c][c];
        return v;
    endfunction

    task automatic sb_pop(input int kind, input logic [FW-1:0] a, input logic [FW-1:0] b);
        exp_t e;
        n_checks++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got kind=%0d at cycle %0d, expected no output", kind, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.a !== a || e.b !== b) begin
                n_fail++;
                $display("FAIL sb_event: got kind=%0d cyc=%0d a=%h b=%h, expected kind=%0d cyc=%0d a=%h b=%h",
                         kind, cyc, a, b, e.kind, e.cyc, e.a, e.b);
            end
        end
    endtask

    // Monitor: every output event is matched against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.clr_acc_o) sb_pop(0, '0, '0);
            if (bus.feed_valid_o) sb_pop(1, bus.a_feed_o, bus.b_feed_o);
            else chk("feed_zero_when_invalid", {bus.a_feed_o, bus.b_feed_o}, 64'd0);
            if (bus.done_o) sb_pop(2, '0, '0);
        end
    end

    task automatic random_mats();
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                ma[r][c] = DW'($urandom());
                mb[r][c] = DW'($urandom());
            end
    endtask

    task automatic drive_operands(input int nc, input int kc, input int mc);
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                bus.a_in_i[r*BW + c*DW +: DW] = ma[r][c];
                bus.b_in_i[r*BW + c*DW +: DW] = mb[r][c];
            end
        bus.dim_n_i = 2'(nc);
        bus.dim_k_i = 2'(kc);
        bus.dim_m_i = 2'(mc);
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < OPW / 32; i++) begin
            bus.a_in_i[i*32 +: 32] = $urandom();
            bus.b_in_i[i*32 +: 32] = $urandom();
        end
        bus.dim_n_i = 2'($urandom_range(0, 3));
        bus.dim_k_i = 2'($urandom_range(0, 3));
        bus.dim_m_i = 2'($urandom_range(0, 3));
    endtask

    // mode 0: full run, start held 'hold' cycles past DONE, then dropped.
    // mode 1: start dropped during cycle offset j (j<0 -> the DONE cycle).
    // mode 2: reset pulsed during cycle offset j, start left high on return.
    // Called at a negedge; returns at a negedge.
    task automatic run_op(input int nc, input int kc, input int mc,
                          input int mode, input int j_in, input int hold);
        int n, k, m, f, done_off, last, s, j;
        exp_t e;
        n = ((nc > MD - 1) ? MD - 1 : nc) + 1;
        k = ((kc > MD - 1) ? MD - 1 : kc) + 1;
        m = ((mc > MD - 1) ? MD - 1 : mc) + 1;
        f = n + k + m - 2;
        done_off = 3 + f + PL;
        j = (j_in < 0 || j_in > done_off) ? done_off : j_in;
        last = (mode == 0) ? done_off : j;
        drive_operands(nc, kc, mc);
        s = cyc;
        if (last >= 2) begin
            e.kind = 0; e.cyc = s + 2; e.a = '0; e.b = '0; q.push_back(e);
        end
        for (int t = 0; t < f; t++)
            if (3 + t <= last) begin
                e.kind = 1; e.cyc = s + 3 + t; e.a = model_a(t, n, k); e.b = model_b(t, k, m);
                q.push_back(e);
            end
        if (done_off <= last) begin
            e.kind = 2; e.cyc = s + done_off; e.a = '0; e.b = '0; q.push_back(e);
        end
        bus.start_i = 1'b1;
        for (int off = 1; off <= last; off++) begin
            @(negedge clk);
            if (off == 1) chk("busy_in_load", bus.busy_o, 64'd1);
            if (off == 2) scramble_inputs();
        end
        if (mode == 0) begin
            chk("busy_in_done", bus.busy_o, 64'd1);
            repeat (hold) @(negedge clk);
            chk("busy_in_release", bus.busy_o, 64'd0);
`ifdef MATMUL_SEQ_PERF_EN
            chk("cycle_cnt_full", cycle_cnt, 64'(done_off));
`endif
            bus.start_i = 1'b0;
            repeat (2) @(negedge clk);
        end else if (mode == 1) begin
            bus.start_i = 1'b0;
            @(negedge clk);
            chk("busy_after_drop", bus.busy_o, 64'd0);
`ifdef MATMUL_SEQ_PERF_EN
            chk("cycle_cnt_abort", cycle_cnt, 64'(j));
`endif
        end else begin
            rst = 1'b1;
            @(negedge clk);
            chk("busy_after_reset", bus.busy_o, 64'd0);
`ifdef MATMUL_SEQ_PERF_EN
            chk("cycle_cnt_reset", cycle_cnt, 64'd0);
`endif
            rst = 1'b0;
        end
    endtask

    initial begin
        int mode, nc, kc, mc, j;
        bus.start_i = 1'b0;
        bus.a_in_i  = '0;
        bus.b_in_i  = '0;
        bus.dim_n_i = 2'd0;
        bus.dim_k_i = 2'd0;
        bus.dim_m_i = 2'd0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("reset_busy",       bus.busy_o,       64'd0);
        chk("reset_feed_valid", bus.feed_valid_o, 64'd0);
        chk("reset_clr_acc",    bus.clr_acc_o,    64'd0);
        chk("reset_done",       bus.done_o,       64'd0);

        // 2x2x2 known operands, start on the first cycle after reset.
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end
        ma[0][0] = 8'd1; ma[0][1] = 8'd2; ma[1][0] = 8'd3; ma[1][1] = 8'd4;
        mb[0][0] = 8'd5; mb[0][1] = 8'd6; mb[1][0] = 8'd7; mb[1][1] = 8'd8;
        rst = 1'b0;
        run_op(1, 1, 1, 0, 0, 3);

        random_mats(); run_op(3, 3, 3, 0, 0, 1);   // full 4x4x4
        random_mats(); run_op(0, 3, 1, 0, 0, 2);   // N=1 K=4 M=2
        random_mats(); run_op(1, 1, 1, 1, 5, 0);   // drop at feed step 2
        random_mats(); run_op(1, 1, 1, 0, 0, 1);   // restart completes
        random_mats(); run_op(2, 2, 2, 2, 4, 0);   // reset mid-feed
        random_mats(); run_op(2, 1, 3, 0, 0, 4);   // immediate start, held in RELEASE
        random_mats(); run_op(1, 2, 3, 1, -1, 0);  // drop in the DONE cycle
        random_mats(); run_op(3, 0, 2, 1, 1, 0);   // drop during LOAD

        for (int i = 0; i < 25; i++) begin
            random_mats();
            nc = $urandom_range(0, 3);
            kc = $urandom_range(0, 3);
            mc = $urandom_range(0, 3);
            mode = $urandom_range(0, 3);
            if (mode == 3) mode = 0;
            j = $urandom_range(1, 3 + (nc + kc + mc + 1) + PL);
            run_op(nc, kc, mc, mode, j, $urandom_range(1, 3));
            if (mode != 2) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        if (bus.start_i) begin
            random_mats();
            run_op(0, 0, 0, 0, 0, 1);
        end

        repeat (6) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
